// File: rtl/lane_overlay_pkg.sv
// Shared constants, trig tables and FSM state type for the lane overlay stage.
// The trig tables match the ones the Hough voter uses, so rho conventions agree.
package lane_overlay_pkg;

  localparam int unsigned THETA_BITS = 8;
  localparam int unsigned TRIG_FRAC  = 10;

  // round(sin(deg) * 1024) for 0..90; the full 0..179 tables are folded from this quadrant.
  localparam int unsigned QSIN [0:90] = '{
       0,   18,   36,   54,   71,   89,  107,  125,  143,  160,
     178,  195,  213,  230,  248,  265,  282,  299,  316,  333,
     350,  367,  384,  400,  416,  433,  449,  465,  481,  496,
     512,  527,  543,  558,  573,  587,  602,  616,  630,  644,
     658,  672,  685,  698,  711,  724,  737,  749,  761,  773,
     784,  796,  807,  818,  828,  839,  849,  859,  868,  878,
     887,  896,  904,  912,  920,  928,  935,  943,  949,  956,
     962,  968,  974,  979,  984,  989,  994,  998, 1002, 1005,
    1008, 1011, 1014, 1016, 1018, 1020, 1022, 1023, 1023, 1024,
    1024
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WRITE,
    S_DONE
  } overlay_state_t;

  function automatic logic signed [15:0] sin_lut(input logic [THETA_BITS-1:0] t);
    logic [6:0] i;
    i = (t <= THETA_BITS'(90)) ? 7'(t) : 7'(THETA_BITS'(180) - t);
    return $signed(16'(QSIN[i]));
  endfunction

  function automatic logic signed [15:0] cos_lut(input logic [THETA_BITS-1:0] t);
    logic [6:0] i;
    if (t <= THETA_BITS'(90)) begin
      i = 7'(THETA_BITS'(90) - t);
      return $signed(16'(QSIN[i]));
    end
    i = 7'(t - THETA_BITS'(90));
    return -$signed(16'(QSIN[i]));
  endfunction

  function automatic logic [THETA_BITS-1:0] theta_clamp(input logic [THETA_BITS-1:0] t);
    return (t >= THETA_BITS'(180)) ? THETA_BITS'(179) : t;
  endfunction

endpackage

// File: rtl/lane_overlay_if.sv
// Line parameters, image BRAM read port, output FIFO write port and done flag.
interface lane_overlay_if #(
  parameter int unsigned ADDR_W = 19
);
  import lane_overlay_pkg::*;

  logic                   start;
  logic signed [15:0]     left_rho;
  logic signed [15:0]     right_rho;
  logic [THETA_BITS-1:0]  left_theta;
  logic [THETA_BITS-1:0]  right_theta;
  logic [ADDR_W-1:0]      image_bram_rd_addr;
  logic [23:0]            image_bram_rd_data;
  logic                   out_wr_en;
  logic                   out_full;
  logic [23:0]            out_din;
  logic                   done;

  modport master (
    output start, left_rho, right_rho, left_theta, right_theta,
    output image_bram_rd_data, out_full,
    input  image_bram_rd_addr, out_wr_en, out_din, done
  );

  modport slave (
    input  start, left_rho, right_rho, left_theta, right_theta,
    input  image_bram_rd_data, out_full,
    output image_bram_rd_addr, out_wr_en, out_din, done
  );

endinterface

// File: rtl/lane_overlay_line_test.sv
// Projects (x, y) onto one (rho, theta) line and registers whether the pixel lies on it.
module lane_overlay_line_test
  import lane_overlay_pkg::*;
#(
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 10,
  parameter int unsigned Y_START  = 0,
  parameter int unsigned LINE_TOL = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [X_W-1:0]         x,
  input  logic [Y_W-1:0]         y,
  input  logic signed [15:0]     rho,
  input  logic [THETA_BITS-1:0]  theta,
  output logic                   on_line
);

  logic signed [15:0] cs, sn;
  logic signed [31:0] xs, ys, cs_ext, sn_ext, rho_ext, sum, pl, diff;
  logic [31:0]        mag;
  logic               on_line_c;

  // pl = (x*cos + y*sin) >>> TRIG_FRAC in 32-bit signed math
  always_comb begin
    cs        = cos_lut(theta);
    sn        = sin_lut(theta);
    xs        = $signed(32'(x));
    ys        = $signed(32'(y));
    cs_ext    = {{16{cs[15]}}, cs};
    sn_ext    = {{16{sn[15]}}, sn};
    rho_ext   = {{16{rho[15]}}, rho};
    sum       = xs * cs_ext + ys * sn_ext;
    pl        = sum >>> TRIG_FRAC;
    diff      = pl - rho_ext;
    mag       = diff[31] ? 32'(-diff) : 32'(diff);
    on_line_c = (32'(y) >= Y_START) && (mag <= LINE_TOL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      on_line <= 1'b0;
    end else if (load) begin
      on_line <= on_line_c;
    end
  end

endmodule

// File: rtl/lane_overlay.sv
// Raster-scans the stored frame, recolours pixels on the detected lane lines and streams every pixel to the output FIFO.
module lane_overlay
  import lane_overlay_pkg::*;
#(
  parameter int unsigned WIDTH       = 720,
  parameter int unsigned HEIGHT      = 540,
  parameter int unsigned Y_START     = HEIGHT / 2,
  parameter int unsigned LINE_TOL    = 1,
  parameter logic [23:0] LEFT_COLOR  = 24'hFF0000,
  parameter logic [23:0] RIGHT_COLOR = 24'h0000FF
) (
  input  logic           clock,
  input  logic           reset,
  lane_overlay_if.slave  bus
);

  localparam int unsigned IMAGE_SIZE = WIDTH * HEIGHT;
  localparam int unsigned ADDR_W     = $clog2(IMAGE_SIZE);
  localparam int unsigned X_W        = $clog2(WIDTH);
  localparam int unsigned Y_W        = $clog2(HEIGHT);

  overlay_state_t         state_q, state_d;
  logic [X_W-1:0]         x_q;
  logic [Y_W-1:0]         y_q;
  logic [ADDR_W-1:0]      addr_q;
  logic signed [15:0]     lrho_q, rrho_q;
  logic [THETA_BITS-1:0]  lth_q, rth_q;
  logic [23:0]            pixel_q;
  logic                   done_q;
  logic                   on_left, on_right;
  logic                   load_frame, advance, last_px;

  assign last_px = (x_q == X_W'(WIDTH - 1)) && (y_q == Y_W'(HEIGHT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    advance    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          load_frame = 1'b1;
          state_d    = S_READ;
        end
      end
      S_READ:  state_d = S_CALC;
      S_CALC:  state_d = S_WRITE;
      S_WRITE: begin
        if (!bus.out_full) begin
          advance = 1'b1;
          state_d = last_px ? S_DONE : S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address is loaded ahead of S_READ so BRAM data lands in S_CALC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      lrho_q  <= '0;
      rrho_q  <= '0;
      lth_q   <= '0;
      rth_q   <= '0;
      pixel_q <= '0;
      done_q  <= 1'b0;
    end else begin
      if (load_frame) begin
        lrho_q <= bus.left_rho;
        rrho_q <= bus.right_rho;
        lth_q  <= theta_clamp(bus.left_theta);
        rth_q  <= theta_clamp(bus.right_theta);
        x_q    <= '0;
        y_q    <= '0;
        addr_q <= '0;
      end else if (advance && !last_px) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (x_q == X_W'(WIDTH - 1)) begin
          x_q <= '0;
          y_q <= y_q + Y_W'(1);
        end else begin
          x_q <= x_q + X_W'(1);
        end
      end
      if (state_q == S_CALC) pixel_q <= bus.image_bram_rd_data;
      done_q <= (state_d == S_DONE);
    end
  end

  lane_overlay_line_test #(
    .X_W(X_W), .Y_W(Y_W), .Y_START(Y_START), .LINE_TOL(LINE_TOL)
  ) u_left (
    .clock(clock), .reset(reset), .load(state_q == S_CALC),
    .x(x_q), .y(y_q), .rho(lrho_q), .theta(lth_q), .on_line(on_left)
  );

  lane_overlay_line_test #(
    .X_W(X_W), .Y_W(Y_W), .Y_START(Y_START), .LINE_TOL(LINE_TOL)
  ) u_right (
    .clock(clock), .reset(reset), .load(state_q == S_CALC),
    .x(x_q), .y(y_q), .rho(rrho_q), .theta(rth_q), .on_line(on_right)
  );

  assign bus.image_bram_rd_addr = addr_q;
  assign bus.out_wr_en          = advance;
  assign bus.out_din            = on_left ? LEFT_COLOR : (on_right ? RIGHT_COLOR : pixel_q);
  assign bus.done               = done_q;

endmodule

// File: tb/tb_lane_overlay.sv
// Scoreboard bench for lane_overlay on an 8x4 frame; two instances differ only in Y_START (0 and 2).
module tb_lane_overlay;

  localparam int unsigned W   = 8;
  localparam int unsigned H   = 4;
  localparam int unsigned AW  = 5;
  localparam int          TOL = 0;
  localparam int          NPX = W * H;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lane_overlay_if #(.ADDR_W(AW)) bus0 ();
  lane_overlay_if #(.ADDR_W(AW)) bus1 ();

  lane_overlay #(.WIDTH(W), .HEIGHT(H), .Y_START(0), .LINE_TOL(TOL),
                 .LEFT_COLOR(24'hFF0000), .RIGHT_COLOR(24'h0000FF))
    u_dut0 (.clock(clk), .reset(rst_n), .bus(bus0.slave));

  lane_overlay #(.WIDTH(W), .HEIGHT(H), .Y_START(2), .LINE_TOL(TOL),
                 .LEFT_COLOR(24'hFF0000), .RIGHT_COLOR(24'h0000FF))
    u_dut1 (.clock(clk), .reset(rst_n), .bus(bus1.slave));

  assign bus1.start       = bus0.start;
  assign bus1.left_rho    = bus0.left_rho;
  assign bus1.right_rho   = bus0.right_rho;
  assign bus1.left_theta  = bus0.left_theta;
  assign bus1.right_theta = bus0.right_theta;
  assign bus1.out_full    = bus0.out_full;

  // Image BRAM: pixel value equals its address, one cycle read latency.
  always @(posedge clk) begin
    bus0.image_bram_rd_data <= 24'(bus0.image_bram_rd_addr);
    bus1.image_bram_rd_data <= 24'(bus1.image_bram_rd_addr);
  end

  logic [23:0] q0[$];
  logic [23:0] q1[$];
  int n_vec = 0;
  int n_err = 0;
  int wr0 = 0;
  int wr1 = 0;

  function automatic int proj(int x, int y, int th);
    int t;
    t = (th > 179) ? 179 : th;
    case (t)
      0:       return x;
      90:      return y;
      179:     return (-1024 * x + 18 * y) >>> 10;
      default: return -100000;
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(int a, int ys, int lr, int lt, int rr, int rt);
    int x, y, dl, dr;
    x  = a % W;
    y  = a / W;
    dl = proj(x, y, lt) - lr;
    dr = proj(x, y, rt) - rr;
    if (dl < 0) dl = -dl;
    if (dr < 0) dr = -dr;
    if (y >= ys && dl <= TOL) return 24'hFF0000;
    if (y >= ys && dr <= TOL) return 24'h0000FF;
    return 24'(a);
  endfunction

  task automatic scoreboard_monitor();
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (bus0.out_wr_en) begin
        n_vec++;
        if (q0.size() == 0) begin
          n_err++; $display("FAIL sb0_extra_write idx=%0d din=%h want=none", wr0, bus0.out_din);
        end else begin
          e = q0.pop_front();
          if (bus0.out_din !== e) begin
            n_err++; $display("FAIL sb0_pixel idx=%0d got=%h want=%h", wr0, bus0.out_din, e);
          end
        end
        wr0++;
      end
      if (bus1.out_wr_en) begin
        n_vec++;
        if (q1.size() == 0) begin
          n_err++; $display("FAIL sb1_extra_write idx=%0d din=%h want=none", wr1, bus1.out_din);
        end else begin
          e = q1.pop_front();
          if (bus1.out_din !== e) begin
            n_err++; $display("FAIL sb1_pixel idx=%0d got=%h want=%h", wr1, bus1.out_din, e);
          end
        end
        wr1++;
      end
    end
  endtask

  task automatic start_frame(input int lr, input int lt, input int rr, input int rt);
    @(posedge clk); #1;
    bus0.left_rho    = 16'(lr);
    bus0.left_theta  = 8'(lt);
    bus0.right_rho   = 16'(rr);
    bus0.right_theta = 8'(rt);
    bus0.start       = 1'b1;
    wr0 = 0;
    wr1 = 0;
    for (int a = 0; a < NPX; a++) begin
      q0.push_back(exp_pix(a, 0, lr, lt, rr, rt));
      q1.push_back(exp_pix(a, 2, lr, lt, rr, rt));
    end
    @(posedge clk); #1;
    bus0.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus0.done && bus1.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.out_full = 1'b0;
    bus0.left_rho = '0; bus0.right_rho = '0; bus0.left_theta = '0; bus0.right_theta = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus0.image_bram_rd_addr !== '0) begin n_err++; $display("FAIL rst_addr got=%h want=0", bus0.image_bram_rd_addr); end
    n_vec++; if (bus0.out_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en got=%b want=0", bus0.out_wr_en); end
    n_vec++; if (bus0.out_din !== 24'h0) begin n_err++; $display("FAIL rst_din got=%h want=0", bus0.out_din); end
    n_vec++; if (bus0.done !== 1'b0 || bus1.done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b/%b want=0", bus0.done, bus1.done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (bus0.out_wr_en !== 1'b0 || bus0.done !== 1'b0) begin n_err++; $display("FAIL idle_quiet wr=%b done=%b want 0/0", bus0.out_wr_en, bus0.done); end
  endtask

  task automatic test_stationary();
    bit ok;
    start_frame(3, 0, 100, 90);
    @(negedge clk);
    n_vec++; if (bus0.out_wr_en !== 1'b0 || bus0.image_bram_rd_addr !== '0) begin n_err++; $display("FAIL lat_read wr=%b addr=%h want 0/0", bus0.out_wr_en, bus0.image_bram_rd_addr); end
    @(negedge clk);
    n_vec++; if (bus0.out_wr_en !== 1'b0) begin n_err++; $display("FAIL lat_calc got=%b want=0", bus0.out_wr_en); end
    @(negedge clk);
    n_vec++; if (bus0.out_wr_en !== 1'b1) begin n_err++; $display("FAIL lat_first_write got=%b want=1", bus0.out_wr_en); end
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stat_timeout done=%b/%b want=1", bus0.done, bus1.done); end
    @(negedge clk);
    n_vec++; if (wr0 !== NPX || wr1 !== NPX) begin n_err++; $display("FAIL stat_count got=%0d/%0d want=%0d", wr0, wr1, NPX); end
    n_vec++; if (q0.size() != 0 || q1.size() != 0) begin n_err++; $display("FAIL stat_left got=%0d/%0d want=0", q0.size(), q1.size()); end
    n_vec++; if (bus0.done !== 1'b1) begin n_err++; $display("FAIL stat_done_held got=%b want=1", bus0.done); end
  endtask

  task automatic test_priority();
    bit ok;
    start_frame(5, 0, 2, 90);
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL prio_timeout done=%b/%b want=1", bus0.done, bus1.done); end
    @(negedge clk);
    n_vec++; if (wr0 !== NPX || wr1 !== NPX) begin n_err++; $display("FAIL prio_count got=%0d/%0d want=%0d", wr0, wr1, NPX); end
  endtask

  task automatic test_ystart();
    bit ok;
    start_frame(1, 0, 100, 90);
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ystart_timeout done=%b/%b want=1", bus0.done, bus1.done); end
    @(negedge clk);
    n_vec++; if (wr0 !== NPX || wr1 !== NPX) begin n_err++; $display("FAIL ystart_count got=%0d/%0d want=%0d", wr0, wr1, NPX); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit found;
    logic [23:0] held;
    start_frame(3, 0, 100, 90);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (wr0 == 5) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL bp_reach got=%0d want=5", wr0); end
    bus0.out_full = 1'b1;
    held = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_vec++; if (bus0.out_wr_en !== 1'b0 || bus1.out_wr_en !== 1'b0) begin n_err++; $display("FAIL bp_wr_en cyc=%0d got=%b/%b want=0", k, bus0.out_wr_en, bus1.out_wr_en); end
      if (k == 3) begin
        held = bus0.out_din;
        n_vec++; if (held !== exp_pix(5, 0, 3, 0, 100, 90)) begin n_err++; $display("FAIL bp_pixel got=%h want=%h", held, exp_pix(5, 0, 3, 0, 100, 90)); end
      end else if (k > 3) begin
        n_vec++; if (bus0.out_din !== held) begin n_err++; $display("FAIL bp_stable cyc=%0d got=%h want=%h", k, bus0.out_din, held); end
      end
    end
    @(posedge clk); #1;
    bus0.out_full = 1'b0;
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_timeout done=%b/%b want=1", bus0.done, bus1.done); end
    @(negedge clk);
    n_vec++; if (wr0 !== NPX || wr1 !== NPX) begin n_err++; $display("FAIL bp_count got=%0d/%0d want=%0d", wr0, wr1, NPX); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bit found;
    start_frame(3, 0, 2, 90);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (wr0 == 12) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL mid_reach got=%0d want=12", wr0); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus0.out_wr_en !== 1'b0 || bus0.done !== 1'b0 || bus0.image_bram_rd_addr !== '0)
      begin n_err++; $display("FAIL mid_abort wr=%b done=%b addr=%h want 0/0/0", bus0.out_wr_en, bus0.done, bus0.image_bram_rd_addr); end
    q0.delete();
    q1.delete();
    repeat (4) @(negedge clk);
    n_vec++; if (wr0 !== 12) begin n_err++; $display("FAIL mid_no_write got=%0d want=12", wr0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_frame(1, 0, 3, 90);
    @(negedge clk);
    n_vec++; if (bus0.image_bram_rd_addr !== '0) begin n_err++; $display("FAIL mid_restart_addr got=%h want=0", bus0.image_bram_rd_addr); end
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mid_timeout done=%b/%b want=1", bus0.done, bus1.done); end
    @(negedge clk);
    n_vec++; if (wr0 !== NPX || wr1 !== NPX) begin n_err++; $display("FAIL mid_count got=%0d/%0d want=%0d", wr0, wr1, NPX); end
  endtask

  task automatic test_rerun_ignore();
    bit ok;
    start_frame(2, 0, 100, 90);
    @(posedge clk); #1;
    bus0.left_rho = 16'(6);
    bus0.start    = 1'b1;
    @(posedge clk); #1;
    bus0.start    = 1'b0;
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ign_timeout done=%b/%b want=1", bus0.done, bus1.done); end
    @(negedge clk);
    n_vec++; if (wr0 !== NPX || wr1 !== NPX) begin n_err++; $display("FAIL ign_count got=%0d/%0d want=%0d", wr0, wr1, NPX); end
    start_frame(-2, 200, 1, 90);
    n_vec++; if (bus0.done !== 1'b0) begin n_err++; $display("FAIL rerun_done_clear got=%b want=0", bus0.done); end
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rerun_timeout done=%b/%b want=1", bus0.done, bus1.done); end
    @(negedge clk);
    n_vec++; if (wr0 !== NPX || wr1 !== NPX) begin n_err++; $display("FAIL rerun_count got=%0d/%0d want=%0d", wr0, wr1, NPX); end
    n_vec++; if (q0.size() != 0 || q1.size() != 0) begin n_err++; $display("FAIL rerun_left got=%0d/%0d want=0", q0.size(), q1.size()); end
  endtask

  initial begin
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_stationary();
    test_priority();
    test_ystart();
    test_backpressure();
    test_reset_midframe();
    test_rerun_ignore();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lane_overlay.md
Name: lane_overlay

Overview:
Output stage directly downstream of the Hough line detector. After hough_done pulses, it scans the stored original RGB frame out of the image BRAM in raster order. Each pixel on the detected left or right lane line is recoloured, and every pixel is pushed into an output FIFO for readout. It is the final stage of the lane-detection pipeline.

Parameters:
WIDTH, 720, image width in pixels
HEIGHT, 540, image height in pixels
IMAGE_SIZE, WIDTH*HEIGHT, BRAM depth; address width is $clog2(IMAGE_SIZE)
Y_START, HEIGHT/2, first row on which lines may be drawn
LINE_TOL, 1, max |pixel_rho - line_rho| counted as on-line
LEFT_COLOR, 24'hFF0000, colour for left-line pixels
RIGHT_COLOR, 24'h0000FF, colour for right-line pixels

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low (0 = reset)
start  in  1  one-cycle pulse; tie to hough_done
left_rho  in  16 signed  left line rho, in pixels
right_rho  in  16 signed  right line rho, in pixels
left_theta  in  THETA_BITS  left line angle index, in degrees
right_theta  in  THETA_BITS  right line angle index, in degrees
image_bram_rd_addr  out  $clog2(IMAGE_SIZE)  raster read address
image_bram_rd_data  in  24  pixel data, valid 1 cycle after the address
out_wr_en  out  1  output FIFO write strobe
out_full  in  1  output FIFO full
out_din  out  24  output pixel
done  out  1  frame fully emitted

Behaviour:
- Reset (asynchronous, reset==0):
  - state=S_IDLE; x=0, y=0.
  - image_bram_rd_addr=0, out_wr_en=0, out_din=0, done=0.
  - Latched rho/theta cleared.
  - Reset asserted mid-frame aborts the frame; no further FIFO writes occur.
- FSM states: S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE.
- S_IDLE:
  - On start=1, latch both rho and both theta values, clear x/y, go to S_READ.
  - start is ignored in S_READ, S_CALC and S_WRITE.
- S_READ: drive registered image_bram_rd_addr = y*WIDTH + x, then go to S_CALC.
- S_CALC: rd_data is valid this cycle. Register:
  - pixel
  - pl = (x*COS_LUT[lt] + y*SIN_LUT[lt]) >>> TRIG_FRAC
  - pr, computed the same way with rt
  - then go to S_WRITE.
- Arithmetic:
  - x and y are zero-extended to signed.
  - Products and sums use 32-bit signed math.
  - Shift is arithmetic.
  - Compare against the rho value sign-extended to 32 bits.
- S_WRITE, output pixel selection:
  - on_left = (y >= Y_START) && |pl - left_rho| <= LINE_TOL.
  - on_right = (y >= Y_START) && |pr - right_rho| <= LINE_TOL.
  - out_din = LEFT_COLOR if on_left; else RIGHT_COLOR if on_right; else the original pixel. Left wins when both are true.
- S_WRITE, handshake:
  - If out_full==0: out_wr_en=1 for exactly one cycle, advance x, then go to S_READ.
  - If out_full==1: out_wr_en=0, out_din held stable, remain in S_WRITE. No pixel is dropped or duplicated.
- Raster advance:
  - When x==WIDTH-1, wrap x to 0 and increment y.
  - The write of pixel (WIDTH-1, HEIGHT-1) goes to S_DONE.
- S_DONE:
  - done=1, held.
  - A new start pulse clears done, relatches inputs and rescans from (0,0).
- Throughput and latency:
  - 3 cycles per pixel when the FIFO is not full; exactly IMAGE_SIZE writes per frame.
  - First out_wr_en occurs 3 cycles after the start cycle.
- Theta indices >= 180 are clamped to 179 at latch time.

Decomposition:
- Shared package, added to globals.sv:
  - TRIG_FRAC=10.
  - SIN_LUT[0:179] and COS_LUT[0:179] as 16-bit signed constants, round(sin/cos(deg)*1024).
  - The same tables the hough stage uses for voting, so rho conventions match exactly.
  - overlay_state_t enum.
- One sub-module: line_test. It is combinational plus one register stage, computes pl and on_line for a single (rho, theta) pair, and is instantiated twice (left and right).

Test Plan:
- Stationary line: WIDTH=8, HEIGHT=4, Y_START=0, LINE_TOL=0, left theta=0 rho=3, right theta=90 rho=100; image pixel = address value. Required: 32 writes; every x==3 pixel is FF0000; all others equal their address; done=1 after the 32nd write.
- Right line plus priority: right theta=90 rho=2, left theta=0 rho=5. Required: row y=2 is 0000FF except (5,2), which is FF0000.
- Y_START gating: Y_START=2, left theta=0 rho=1. Required: (1,0) and (1,1) keep the original pixel; (1,2) and (1,3) are FF0000.
- Backpressure: hold out_full=1 for 10 cycles at pixel 5. Required: out_wr_en=0 throughout, out_din stable; the write resumes with no loss; total writes = 32.
- Reset mid-frame: drop reset after the 12th write. Required: out_wr_en=0, done=0, addr=0 immediately; a new start rescans from address 0 with 32 writes.
- Rerun and ignore: start pulsed during S_CALC is ignored; start in S_DONE clears done and produces a fresh 32-write frame with the new rho/theta.
